// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC generation with i-cache handshake, branch redirect, decode stall and IF/ID register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BOOT_PC  = 32'hFFFF_FFFC
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_pc,
  input  logic        i_icache_busywait,
  input  logic [31:0] i_icache_instr,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_pc4,
  output logic [31:0] o_ifid_instr,
  output logic        o_ifid_valid
);
  typedef enum logic [1:0] {BOOT, FETCH, PENDING} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [31:0] w_target;
  logic [31:0] w_next_pending;
  assign w_target       = {i_branch_target[31:2], 2'b00};
  assign w_next_pending = i_branch_taken ? w_target : r_pending;
  assign o_pc           = r_pc;
  assign o_ifid_pc      = r_ifid_pc;
  assign o_ifid_pc4     = r_ifid_pc4;
  assign o_ifid_instr   = r_ifid_instr;
  assign o_ifid_valid   = r_ifid_valid;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= BOOT;
      r_pc         <= BOOT_PC;
      r_pending    <= '0;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_pc    <= RESET_PC;
          r_state <= FETCH;
        end
        FETCH: begin
          if (i_branch_taken) begin
            r_ifid_valid <= 1'b0;
            if (i_icache_busywait) begin
              r_pending <= w_target;
              r_state   <= PENDING;
            end else begin
              r_pc <= w_target;
            end
          end else if (!i_stall) begin
            if (i_icache_busywait) begin
              r_ifid_valid <= 1'b0;
            end else begin
              r_ifid_pc    <= r_pc;
              r_ifid_pc4   <= r_pc + 32'd4;
              r_ifid_instr <= i_icache_instr;
              r_ifid_valid <= 1'b1;
              r_pc         <= r_pc + 32'd4;
            end
          end
        end
        PENDING: begin
          // the refill's instruction belongs to the wrong path, so it is dropped
          r_ifid_valid <= 1'b0;
          r_pending    <= w_next_pending;
          if (!i_icache_busywait) begin
            r_pc    <= w_next_pending;
            r_state <= FETCH;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: scoreboard-driven checks of PC sequencing, misses, redirects, stalls and reset
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        busy;
  logic [31:0] instr;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  logic [31:0] exp_pc;
  logic [31:0] kept;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .i_clock(clk), .i_reset(rst), .o_pc(pc), .i_icache_busywait(busy),
    .i_icache_instr(instr), .i_stall(stall), .i_branch_taken(br),
    .i_branch_target(tgt), .o_ifid_pc(ifid_pc), .o_ifid_pc4(ifid_pc4),
    .o_ifid_instr(ifid_instr), .o_ifid_valid(ifid_valid)
  );

  // entries pushed before an edge are the captures expected at that edge
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_pc !== e[63:32] || ifid_pc4 !== e[63:32] + 32'd4 || ifid_instr !== e[31:0]) begin
        n_err++;
        $display("FAIL scoreboard: got valid=%b pc=%h pc4=%h instr=%h, want valid=1 pc=%h pc4=%h instr=%h",
                 ifid_valid, ifid_pc, ifid_pc4, ifid_instr, e[63:32], e[63:32] + 32'd4, e[31:0]);
      end
    end
  end

  task automatic step(input logic b, input logic [31:0] t, input logic s, input logic bz, input logic [31:0] ins);
    br = b; tgt = t; stall = s; busy = bz; instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic hit();
    logic [31:0] ins;
    ins = $urandom;
    sb.push_back({exp_pc, ins});
    step(1'b0, 32'h0, 1'b0, 1'b0, ins);
    exp_pc += 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold: pc=%h valid=%b ifid_pc=%h, want fffffffc/0/0", pc, ifid_valid, ifid_pc);
      end
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'h0;
    n_cmp++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: pc=%h valid=%b, want 00000000/0", pc, ifid_valid);
    end
  endtask

  task automatic test_hits();
    for (int i = 0; i < 4; i++) begin
      hit();
      n_cmp++;
      if (pc !== exp_pc) begin
        n_err++;
        $display("FAIL hits_pc: pc=%h want %h", pc, exp_pc);
      end
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      n_cmp++;
      if (pc !== 32'h10 || ifid_valid !== 1'b0) begin
        n_err++;
        $display("FAIL miss_hold cycle %0d: pc=%h valid=%b, want 00000010/0", i, pc, ifid_valid);
      end
    end
    hit();
    n_cmp++;
    if (pc !== 32'h14) begin
      n_err++;
      $display("FAIL miss_resume: pc=%h want 00000014", pc);
    end
  endtask

  task automatic test_branch_hit();
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'h0;
    hit();
    hit();
    step(1'b1, 32'h43, 1'b0, 1'b0, $urandom);
    exp_pc = 32'h40;
    n_cmp++;
    if (pc !== 32'h40 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL branch_hit: pc=%h valid=%b, want 00000040/0", pc, ifid_valid);
    end
    hit();
    n_cmp++;
    if (pc !== 32'h44) begin
      n_err++;
      $display("FAIL branch_hit_next: pc=%h want 00000044", pc);
    end
  endtask

  task automatic test_branch_miss();
    step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h80, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pc !== 32'h20 || ifid_valid !== 1'b0) begin
        n_err++;
        $display("FAIL pending_hold %0d: pc=%h valid=%b, want 00000020/0", i, pc, ifid_valid);
      end
      step(1'b0, 32'h0, i[0], 1'b1, $urandom);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, $urandom);
    exp_pc = 32'h80;
    n_cmp++;
    if (pc !== 32'h80 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pending_release: pc=%h valid=%b, want 00000080/0", pc, ifid_valid);
    end
    hit();
    step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h204, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    n_cmp++;
    if (pc !== 32'h84) begin
      n_err++;
      $display("FAIL pending_overwrite_hold: pc=%h want 00000084", pc);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'h204;
    n_cmp++;
    if (pc !== 32'h204 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pending_overwrite: pc=%h valid=%b, want 00000204/0", pc, ifid_valid);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
    exp_pc = 32'h300;
    n_cmp++;
    if (pc !== 32'h300 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_vs_branch: pc=%h valid=%b, want 00000300/0", pc, ifid_valid);
    end
    kept = $urandom;
    sb.push_back({exp_pc, kept});
    step(1'b0, 32'h0, 1'b0, 1'b0, kept);
    exp_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, i[0], $urandom);
      n_cmp++;
      if (pc !== 32'h304 || ifid_pc !== 32'h300 || ifid_pc4 !== 32'h304 || ifid_instr !== kept || ifid_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold %0d: pc=%h ifid_pc=%h pc4=%h instr=%h valid=%b, want 00000304/00000300/00000304/%h/1",
                 i, pc, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, kept);
      end
    end
    hit();
    n_cmp++;
    if (pc !== 32'h308) begin
      n_err++;
      $display("FAIL stall_release: pc=%h want 00000308", pc);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'hFFFF_FFFC;
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_target: pc=%h want fffffffc", pc);
    end
    hit();
    n_cmp++;
    if (pc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc: pc=%h want 00000000", pc);
    end
  endtask

  task automatic test_reset_pending();
    step(1'b1, 32'h500, 1'b0, 1'b1, 32'h0);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_pending: pc=%h valid=%b ifid_pc=%h instr=%h, want fffffffc/0/0/0", pc, ifid_valid, ifid_pc, ifid_instr);
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'h0;
    n_cmp++;
    if (pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_pending_boot: pc=%h want 00000000", pc);
    end
    hit();
    n_cmp++;
    if (pc !== 32'h4) begin
      n_err++;
      $display("FAIL reset_pending_lost: pc=%h want 00000004", pc);
    end
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; instr = '0; stall = 1'b0; br = 1'b0; tgt = '0; exp_pc = '0;
    test_reset();
    test_hits();
    test_miss();
    test_branch_hit();
    test_branch_miss();
    test_stall();
    test_wrap();
    test_reset_pending();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
